shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Controller for a single-port 2**ADDR_W-word register-file memory that is shared by NUM_REQ requesters.
- Grants one requester per cycle with round-robin fairness and drives the registered memory command port.
- Returns read data tagged with the requester ID.
- Runs a clear sequence that zeroes every word, automatically after reset and on demand via clr_start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- ADDR_W, 3, memory address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  per-requester request; acts as a valid.
- req_we  in  NUM_REQ  per-requester select: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; requester k occupies slice [k*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data; sliced the same way.
- gnt  out  NUM_REQ  one-hot grant, combinational; acts as a ready.
- clr_start  in  1  single-cycle request to clear the memory.
- clr_busy  out  1  high while the FSM is in CLEAR.
- clr_done  out  1  one-cycle pulse when the last clear write is on the memory port.
- mem_en  out  1  memory command valid, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read command.
- rd_valid  out  1  read response valid, registered.
- rd_data  out  DATA_W  read response data.
- rd_id  out  ID_W  index of the requester that issued the read.

Behaviour:
- Reset (rst_n=0 at an edge):
  - mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, rd_id, clr_done all go to 0.
  - Round-robin pointer goes to 0 and the clear counter goes to 0.
  - FSM goes to CLEAR.
  - While rst_n=0, gnt=0.
  - A reset during a clear restarts the clear at address 0.
- FSM has two states, CLEAR and ARB.
- CLEAR:
  - clr_busy=1 and gnt=0 regardless of req.
  - Counter cnt runs 0..DEPTH-1, one per cycle.
  - Each CLEAR cycle registers mem_en=1, mem_we=1, mem_addr=cnt, mem_wdata=0.
  - clr_done is registered high in the cycle the cnt=DEPTH-1 write appears on the port.
  - Transition to ARB after the cnt=DEPTH-1 cycle.
  - Timing out of reset, cycle 0 = first cycle with rst_n=1: CLEAR occupies cycles 0..DEPTH-1, writes appear in cycles 1..DEPTH, and cycle DEPTH is the first ARB cycle.
  - clr_start is ignored while in CLEAR.
- ARB:
  - If clr_start=1: no grant that cycle, go to CLEAR with cnt=0. clr_start wins over any req in the same cycle.
  - Otherwise, if any req is high, gnt selects the first requester with req high, searching ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
  - A transfer occurs when req[k]&gnt[k].
  - At the next edge: ptr <= (k+1) mod NUM_REQ; mem_en=1; mem_we=req_we[k]; mem_addr and mem_wdata are taken from slice k.
  - With no req: mem_en=0, ptr holds, and mem_addr/mem_wdata hold.
- Requester obligations:
  - A requester holds req and its operands stable until granted; it may change them in the cycle after its grant.
  - Grants are at most one per cycle, so the sustained throughput is 1 access per cycle.
- Read response:
  - A read granted in cycle t puts the command on the port in t+1.
  - rd_valid=1, rd_data=mem_rdata, rd_id=k in cycle t+2.
  - rd_valid deasserts in cycles without a response; rd_data and rd_id hold.
  - Writes produce no response.
- In-flight reads:
  - A read granted before clr_start still returns its rd_valid normally.
  - Its data is the pre-clear content, because the read reaches the port before the first clear write.
- Ordering: writes and reads reach the port in grant order, so a read granted after a write to the same address returns the new data.

Test Plan:
- Release reset with req=4'b1111 held high, DEPTH=8:
  - gnt=0 in cycles 0..7.
  - mem_we=1, mem_wdata=0, mem_addr=0..7 in cycles 1..8.
  - clr_done=1 only in cycle 8.
  - First grant is gnt=4'b0001 in cycle 8.
- All four req held high in ARB, all reads: gnt sequence 0001, 0010, 0100, 1000, 0001; rd_id sequence 0, 1, 2, 3, 0, each 2 cycles after its grant.
- req0 writes 0xA5 to addr 3, then req2 reads addr 3 the next cycle: rd_valid=1, rd_data=0xA5, rd_id=2, 2 cycles after gnt[2].
- clr_start and req1 both high in the same ARB cycle:
  - gnt=0 that cycle.
  - clr_busy=1 for 8 cycles and 8 zero-writes occur.
  - A subsequent read of addr 3 returns 0x00.
- rst_n low for one cycle while the clear is at cnt=4:
  - All outputs go to 0.
  - The clear restarts at addr 0 and clr_done arrives 8 cycles after reset release.
- req3 read of addr 3 (=0x5A) granted, with clr_start in the next cycle: rd_valid=1, rd_data=0x5A, rd_id=3 still delivered, then the clear proceeds.

Source files
------------

// File: rtl/shared_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// shared_mem_arbiter_if : requester, memory-port, clear and read-response bus
// Revision: 1.0
// ============================================================================
interface shared_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic                      clr_start;
  logic                      clr_busy;
  logic                      clr_done;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ID_W-1:0]           rd_id;

  modport slave (
    input  req, req_we, req_addr, req_wdata, clr_start, mem_rdata,
    output gnt, clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata,
           rd_valid, rd_data, rd_id
  );

  modport master (
    output req, req_we, req_addr, req_wdata, clr_start, mem_rdata,
    input  gnt, clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata,
           rd_valid, rd_data, rd_id
  );
endinterface
`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// shared_mem_arbiter : round-robin arbiter and clear sequencer for a shared RF
// Revision: 1.0
// ============================================================================
module shared_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  shared_mem_arbiter_if.slave bus
);
  localparam int                DEPTH       = 1 << ADDR_W;
  localparam logic [0:0]        c_st_clear  = 1'b0;
  localparam logic [0:0]        c_st_arb    = 1'b1;
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [ID_W-1:0]   c_last_id   = ID_W'(NUM_REQ - 1);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [ADDR_W-1:0]  r_cnt;
  logic [ID_W-1:0]    r_ptr;
  logic               w_clr_busy;
  logic               w_arb_en;
  logic               w_found;
  logic               w_xfer;
  logic [ID_W-1:0]    w_sel;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_rr_idx  [NUM_REQ];
  logic [ADDR_W-1:0]  w_req_addr[NUM_REQ];
  logic [DATA_W-1:0]  w_req_data[NUM_REQ];

  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_clr_done;
  logic               r_port_rd;
  logic [ID_W-1:0]    r_port_id;
  logic               r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;
  logic [ID_W-1:0]    r_rd_id;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign w_req_addr[k] = bus.req_addr[k*ADDR_W +: ADDR_W];
    assign w_req_data[k] = bus.req_wdata[k*DATA_W +: DATA_W];
    assign w_rr_idx[k]   = ID_W'((int'(r_ptr) + k) % NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_clear;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_clear: if (r_cnt == c_last_addr) w_state_nxt = c_st_arb;
      c_st_arb:   if (bus.clr_start)        w_state_nxt = c_st_clear;
      default:    w_state_nxt = c_st_clear;
    endcase
  end

  always_comb begin
    w_clr_busy = 1'b0;
    w_arb_en   = 1'b0;
    case (r_state)
      c_st_clear: w_clr_busy = 1'b1;
      c_st_arb:   w_arb_en   = ~bus.clr_start;
      default:    w_clr_busy = 1'b0;
    endcase
  end

  // Scan from the farthest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[w_rr_idx[i]]) begin
        w_sel   = w_rr_idx[i];
        w_found = 1'b1;
      end
    end
  end

  assign w_xfer = rst_n & w_arb_en & w_found;
  assign w_gnt  = w_xfer ? (NUM_REQ'(1) << w_sel) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_clr_done  <= 1'b0;
      r_port_rd   <= 1'b0;
      r_port_id   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_id     <= '0;
    end else begin
      r_clr_done <= 1'b0;
      r_port_rd  <= 1'b0;
      if (w_clr_busy) begin
        r_cnt       <= r_cnt + ADDR_W'(1);
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_cnt;
        r_mem_wdata <= '0;
        r_clr_done  <= (r_cnt == c_last_addr);
      end else if (w_xfer) begin
        r_ptr       <= (w_sel == c_last_id) ? '0 : w_sel + ID_W'(1);
        r_mem_en    <= 1'b1;
        r_mem_we    <= bus.req_we[w_sel];
        r_mem_addr  <= w_req_addr[w_sel];
        r_mem_wdata <= w_req_data[w_sel];
        r_port_rd   <= ~bus.req_we[w_sel];
        r_port_id   <= w_sel;
      end else begin
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
        if (bus.clr_start) r_cnt <= '0;
      end
      // Read data is sampled while the command is on the port (async RF read).
      r_rd_valid <= r_port_rd;
      if (r_port_rd) begin
        r_rd_data <= bus.mem_rdata;
        r_rd_id   <= r_port_id;
      end
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.clr_busy  = w_clr_busy;
  assign bus.clr_done  = r_clr_done;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_id     = r_rd_id;
endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_shared_mem_arbiter : scoreboard bench with a transaction-level reference
// Revision: 1.0
// ============================================================================
module tb_shared_mem_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shared_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  shared_mem_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Register-file memory: synchronous write, asynchronous read.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr];

  typedef struct { int due; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; logic done; } cmd_t;
  typedef struct { int due; logic [DATA_W-1:0] data; logic [ID_W-1:0] id; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit                m_clearing;
  int                m_cnt;
  int                m_ptr;
  bit                m_prev_rst;
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                last_k;
  bit                mon_on = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void set_req(int k, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bus.req[k]                          = 1'b1;
    bus.req_we[k]                       = we;
    bus.req_addr[k*ADDR_W +: ADDR_W]    = a;
    bus.req_wdata[k*DATA_W +: DATA_W]   = d;
  endfunction

  function automatic void drop_granted();
    if (last_k >= 0) bus.req[last_k] = 1'b0;
  endfunction

  // One clock cycle: evaluate the model against the inputs now applied, then advance.
  task automatic step();
    logic [NUM_REQ-1:0] eg;
    logic [ADDR_W-1:0]  a;
    logic [DATA_W-1:0]  d;
    int k;
    #1;
    eg = '0;
    k  = -1;
    if (!rst_n) begin
      m_clearing = 1'b1;
      m_cnt      = 0;
      m_ptr      = 0;
      while (cmd_q.size() > 0 && cmd_q[$].due > cyc) void'(cmd_q.pop_back());
      while (rsp_q.size() > 0 && rsp_q[$].due > cyc) void'(rsp_q.pop_back());
    end else begin
      if (m_prev_rst)
        check("reset_outputs", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                bus.rd_valid, bus.rd_data, bus.rd_id, bus.clr_done}, '0);
      check("clr_busy", bus.clr_busy, m_clearing);
      if (m_clearing) begin
        cmd_q.push_back('{cyc + 1, 1'b1, ADDR_W'(m_cnt), '0, m_cnt == DEPTH - 1});
        m_mem[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == DEPTH) m_clearing = 1'b0;
      end else if (bus.clr_start) begin
        m_clearing = 1'b1;
        m_cnt      = 0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          int j;
          j = (m_ptr + i) % NUM_REQ;
          if (k < 0 && bus.req[j]) k = j;
        end
        if (k >= 0) begin
          eg[k] = 1'b1;
          a = bus.req_addr[k*ADDR_W +: ADDR_W];
          d = bus.req_wdata[k*DATA_W +: DATA_W];
          cmd_q.push_back('{cyc + 1, bus.req_we[k], a, d, 1'b0});
          if (bus.req_we[k]) m_mem[a] = d;
          else rsp_q.push_back('{cyc + 2, m_mem[a], ID_W'(k)});
          m_ptr = (k + 1) % NUM_REQ;
        end
      end
    end
    check("gnt", bus.gnt, eg);
    m_prev_rst = !rst_n;
    last_k     = k;
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares the memory port and read responses against the queued expectations.
  initial begin : p_monitor
    bit rst_seen;
    logic [DATA_W-1:0] exp_data;
    logic [ID_W-1:0]   exp_id;
    cmd_t c;
    rsp_t r;
    rst_seen = 1'b0;
    exp_data = '0;
    exp_id   = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rst_seen) begin
          exp_data = '0;
          exp_id   = '0;
        end
        rst_seen = !rst_n;
        while (cmd_q.size() > 0 && cmd_q[0].due < cyc) begin
          c = cmd_q.pop_front();
          n_checks++; n_errors++;
          $display("FAIL mem_cmd_missing: expected command due cyc %0d never seen", c.due);
        end
        if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
          c = cmd_q.pop_front();
          check("mem_cmd", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.clr_done},
                           {1'b1, c.we, c.addr, c.wdata, c.done});
        end else begin
          check("mem_idle", {bus.mem_en, bus.clr_done}, 2'b00);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
          r = rsp_q.pop_front();
          check("rd_resp", {bus.rd_valid, bus.rd_data, bus.rd_id}, {1'b1, r.data, r.id});
          exp_data = r.data;
          exp_id   = r.id;
        end else begin
          check("rd_hold", {bus.rd_valid, bus.rd_data, bus.rd_id}, {1'b0, exp_data, exp_id});
        end
      end
    end
  end

  initial begin : p_stim
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.clr_start = 1'b0;
    last_k        = -1;
    m_prev_rst    = 1'b0;
    step();
    mon_on = 1'b1;
    step();

    // Release reset with all four requesters reading: clear, then round robin.
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, ADDR_W'(k), '0);
    rst_n = 1'b1;
    repeat (DEPTH + 6) step();
    bus.req = '0;
    repeat (2) step();

    // Write then read-after-write from a different requester.
    set_req(0, 1'b1, 3'd3, 8'hA5);
    step(); drop_granted();
    set_req(2, 1'b0, 3'd3, 8'h00);
    step(); drop_granted();
    repeat (3) step();

    // clr_start beats a simultaneous request; the read afterwards sees zero.
    set_req(1, 1'b0, 3'd3, 8'h00);
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    repeat (DEPTH + 3) begin step(); drop_granted(); end

    // Reset in the middle of a clear restarts it from address 0.
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (DEPTH + 2) step();

    // A read in flight when clr_start arrives still returns pre-clear data.
    set_req(0, 1'b1, 3'd3, 8'h5A);
    step(); drop_granted();
    set_req(3, 1'b0, 3'd3, 8'h00);
    step(); drop_granted();
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    repeat (DEPTH + 3) step();

    // Randomized traffic; requesters hold their operands until granted.
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!bus.req[k] || last_k == k) begin
          bus.req[k] = ($urandom_range(0, 9) < 6);
          bus.req_we[k] = $urandom_range(0, 1);
          bus.req_addr[k*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, DEPTH - 1));
          bus.req_wdata[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      bus.clr_start = ($urandom_range(0, 39) == 0);
      rst_n         = ($urandom_range(0, 199) != 0);
      step();
    end

    bus.req       = '0;
    bus.clr_start = 1'b0;
    rst_n         = 1'b1;
    repeat (DEPTH + 4) step();
    check("queues_drained", cmd_q.size() + rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
